// File: rtl/hack_ctrl_if.sv
// Instruction-fetch and data-memory handshake bundle for the Hack control unit.
// The master side belongs to the control unit; the slave side is the memory system.
interface hack_ctrl_if #(
    parameter int unsigned PC_W = 15
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;

    logic [PC_W-1:0] dmem_addr;
    logic            dmem_rd;
    logic            dmem_rvalid;
    logic [15:0]     dmem_rdata;
    logic            dmem_wr;
    logic [15:0]     dmem_wdata;
    logic            dmem_wready;

    modport master (
        output imem_req, imem_addr, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
        input  imem_valid, imem_data, dmem_rvalid, dmem_rdata, dmem_wready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
        output imem_valid, imem_data, dmem_rvalid, dmem_rdata, dmem_wready
    );
endinterface

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack CPU control unit: owns PC/A/D, sequences fetch, decode,
// optional M read, one-cycle ALU execute and optional M write.
module hack_ctrl #(
    parameter int unsigned    PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    hack_ctrl_if.master       bus,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic [5:0]        alu_c,
    input  logic [15:0]       alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       a_reg,
    output logic [15:0]       d_reg
);
    localparam int unsigned DW       = 16;
    localparam logic [5:0]  ALU_ZERO = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MREAD,
        S_EXEC,
        S_MWRITE
    } state_t;

    state_t          state_q, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [DW-1:0]   a_q, a_nxt;
    logic [DW-1:0]   d_q, d_nxt;
    logic [DW-1:0]   ir_q, ir_nxt;
    logic [DW-1:0]   m_q, m_nxt;
    logic [DW-1:0]   res_q, res_nxt;
    logic [PC_W-1:0] addr_q, addr_nxt;
    logic            imem_req_q, dmem_rd_q, dmem_wr_q;
    logic [5:0]      alu_c_q;
    logic [DW-1:0]   alu_y_q;
    logic            jmp;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_nxt;
    end

    // Next-state and datapath next values
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        a_nxt     = a_q;
        d_nxt     = d_q;
        ir_nxt    = ir_q;
        m_nxt     = m_q;
        res_nxt   = res_q;
        addr_nxt  = addr_q;
        jmp       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // imem_req is low for one cycle after reset; valid is ignored then
                if (imem_req_q && bus.imem_valid) begin
                    ir_nxt    = bus.imem_data;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_nxt     = ir_q;
                    pc_nxt    = pc_q + PC_W'(1);
                    state_nxt = S_FETCH;
                end else begin
                    addr_nxt  = a_q[PC_W-1:0];
                    state_nxt = ir_q[12] ? S_MREAD : S_EXEC;
                end
            end
            S_MREAD: begin
                if (bus.dmem_rvalid) begin
                    m_nxt     = bus.dmem_rdata;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                res_nxt  = alu_out;
                addr_nxt = a_q[PC_W-1:0];
                if (ir_q[4]) d_nxt = alu_out;
                if (ir_q[5]) a_nxt = alu_out;
                jmp = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
                pc_nxt    = jmp ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
                state_nxt = ir_q[3] ? S_MWRITE : S_FETCH;
            end
            S_MWRITE: begin
                if (bus.dmem_wready) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Architectural registers and registered handshake/ALU outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            a_q        <= '0;
            d_q        <= '0;
            ir_q       <= '0;
            m_q        <= '0;
            res_q      <= '0;
            addr_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
            alu_c_q    <= ALU_ZERO;
            alu_y_q    <= '0;
        end else begin
            pc_q       <= pc_nxt;
            a_q        <= a_nxt;
            d_q        <= d_nxt;
            ir_q       <= ir_nxt;
            m_q        <= m_nxt;
            res_q      <= res_nxt;
            addr_q     <= addr_nxt;
            imem_req_q <= (state_nxt == S_FETCH);
            dmem_rd_q  <= (state_nxt == S_MREAD);
            dmem_wr_q  <= (state_nxt == S_MWRITE);
            alu_c_q    <= (state_nxt == S_EXEC) ? ir_nxt[11:6] : ALU_ZERO;
            alu_y_q    <= ((state_nxt == S_EXEC) && ir_nxt[12]) ? m_nxt : a_nxt;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_rd    = dmem_rd_q;
    assign bus.dmem_wr    = dmem_wr_q;
    assign bus.dmem_wdata = res_q;

    assign alu_x = d_q;
    assign alu_y = alu_y_q;
    assign alu_c = alu_c_q;
    assign pc    = pc_q;
    assign a_reg = a_q;
    assign d_reg = d_q;
endmodule

// File: tb/tb_hack_ctrl.sv
// Directed bench for hack_ctrl: a reference Hack ALU closes the loop and
// each step compares DUT state against hand-computed values.
module tb_hack_ctrl;
    localparam int unsigned PC_W = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     alu_x, alu_y, alu_out;
    logic [5:0]      alu_c;
    logic            alu_zr, alu_ng;
    logic [PC_W-1:0] pc;
    logic [15:0]     a_reg, d_reg;
    logic [15:0]     ax, ay, ao;

    int checks = 0;
    int errors = 0;

    hack_ctrl_if #(.PC_W(PC_W)) bus();

    hack_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_c   (alu_c),
        .alu_out (alu_out),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng),
        .pc      (pc),
        .a_reg   (a_reg),
        .d_reg   (d_reg)
    );

    always #5 clk = ~clk;

    // Reference Hack ALU
    always_comb begin
        ax = alu_c[5] ? 16'h0000 : alu_x;
        if (alu_c[4]) ax = ~ax;
        ay = alu_c[3] ? 16'h0000 : alu_y;
        if (alu_c[2]) ay = ~ay;
        ao = alu_c[1] ? ax + ay : ax & ay;
        if (alu_c[0]) ao = ~ao;
    end
    assign alu_out = ao;
    assign alu_zr  = (ao == 16'h0000);
    assign alu_ng  = ao[15];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for imem_req, presents one instruction; returns in DECODE
    task automatic fetch(input logic [15:0] instr);
        for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        bus.imem_valid = 1'b1;
        bus.imem_data  = instr;
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'h0000;
    endtask

    initial begin
        reset           = 1'b1;
        bus.imem_valid  = 1'b0;
        bus.imem_data   = 16'h0000;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 16'h0000;
        bus.dmem_wready = 1'b0;
        tick();
        tick();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dmem_rd", 32'(bus.dmem_rd), 32'd0);
        chk("rst_dmem_wr", 32'(bus.dmem_wr), 32'd0);
        chk("rst_alu_c", 32'(alu_c), 32'h2A);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_a", 32'(a_reg), 32'd0);
        chk("rst_d", 32'(d_reg), 32'd0);
        reset = 1'b0;
        tick();

        // 1: A-instruction @5
        chk("t1_req", 32'(bus.imem_req), 32'd1);
        chk("t1_addr0", 32'(bus.imem_addr), 32'd0);
        fetch(16'h0005);
        chk("t1_decode_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("t1_a", 32'(a_reg), 32'd5);
        chk("t1_pc", 32'(pc), 32'd1);
        chk("t1_req_again", 32'(bus.imem_req), 32'd1);
        chk("t1_addr1", 32'(bus.imem_addr), 32'd1);

        // 2: D=A
        fetch(16'hEC10);
        tick();
        chk("t2_alu_c", 32'(alu_c), 32'h30);
        chk("t2_alu_y", 32'(alu_y), 32'd5);
        chk("t2_dmem", 32'({bus.dmem_rd, bus.dmem_wr, bus.imem_req}), 32'd0);
        tick();
        chk("t2_d", 32'(d_reg), 32'd5);
        chk("t2_a", 32'(a_reg), 32'd5);
        chk("t2_pc", 32'(pc), 32'd2);
        chk("t2_nodmem", 32'({bus.dmem_rd, bus.dmem_wr}), 32'd0);

        // 3: @100, D=D+A, M=D with wready after 2 cycles
        fetch(16'h0064);
        tick();
        fetch(16'hE090);
        tick();
        chk("t3_add_c", 32'(alu_c), 32'h02);
        tick();
        chk("t3_d", 32'(d_reg), 32'd105);
        chk("t3_pc", 32'(pc), 32'd4);
        fetch(16'hE308);
        tick();
        chk("t3_passd_c", 32'(alu_c), 32'h0C);
        tick();
        chk("t3_wr1", 32'(bus.dmem_wr), 32'd1);
        chk("t3_waddr", 32'(bus.dmem_addr), 32'd100);
        chk("t3_wdata", 32'(bus.dmem_wdata), 32'd105);
        chk("t3_excl1", 32'({bus.imem_req, bus.dmem_rd}), 32'd0);
        tick();
        chk("t3_wr2", 32'(bus.dmem_wr), 32'd1);
        tick();
        chk("t3_wr3", 32'(bus.dmem_wr), 32'd1);
        chk("t3_waddr3", 32'(bus.dmem_addr), 32'd100);
        bus.dmem_wready = 1'b1;
        tick();
        bus.dmem_wready = 1'b0;
        chk("t3_wr_done", 32'(bus.dmem_wr), 32'd0);
        chk("t3_fetch", 32'(bus.imem_req), 32'd1);
        chk("t3_pc5", 32'(pc), 32'd5);

        // 4: conditional jumps
        fetch(16'h0005); tick();
        fetch(16'hEC10); tick(); tick();
        chk("t4_d5", 32'(d_reg), 32'd5);
        fetch(16'h0028); tick();
        fetch(16'hE301); tick(); tick();
        chk("t4_jgt_taken", 32'(pc), 32'd40);
        chk("t4_jgt_addr", 32'(bus.imem_addr), 32'd40);
        fetch(16'hEA90); tick(); tick();
        chk("t4_d0", 32'(d_reg), 32'd0);
        fetch(16'h0028); tick();
        fetch(16'hE301); tick(); tick();
        chk("t4_jgt_not", 32'(pc), 32'd43);
        fetch(16'hEE90); tick(); tick();
        chk("t4_dneg", 32'(d_reg), 32'hFFFF);
        fetch(16'h0028); tick();
        fetch(16'hE304); tick(); tick();
        chk("t4_jlt_taken", 32'(pc), 32'd40);

        // 5: D=M with rvalid after 3 wait cycles
        fetch(16'h0007); tick();
        fetch(16'hFC10);
        tick();
        chk("t5_rd1", 32'(bus.dmem_rd), 32'd1);
        chk("t5_raddr", 32'(bus.dmem_addr), 32'd7);
        chk("t5_excl", 32'({bus.imem_req, bus.dmem_wr}), 32'd0);
        chk("t5_alu_c_idle", 32'(alu_c), 32'h2A);
        tick();
        tick();
        chk("t5_rd3", 32'(bus.dmem_rd), 32'd1);
        tick();
        chk("t5_rd4", 32'(bus.dmem_rd), 32'd1);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 16'hBEEF;
        tick();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 16'h0000;
        chk("t5_alu_c", 32'(alu_c), 32'h30);
        chk("t5_alu_y", 32'(alu_y), 32'hBEEF);
        chk("t5_rd_done", 32'(bus.dmem_rd), 32'd0);
        tick();
        chk("t5_d", 32'(d_reg), 32'hBEEF);
        chk("t5_a", 32'(a_reg), 32'd7);
        chk("t5_pc", 32'(pc), 32'd42);

        // 6a: reset during MWRITE
        fetch(16'hE308); tick(); tick();
        chk("t6_wr", 32'(bus.dmem_wr), 32'd1);
        chk("t6_wdata", 32'(bus.dmem_wdata), 32'hBEEF);
        reset = 1'b1;
        tick();
        chk("t6_wr_abort", 32'(bus.dmem_wr), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        chk("t6_ad", 32'({a_reg, d_reg}), 32'd0);
        reset = 1'b0;
        tick();
        chk("t6_fetch", 32'(bus.imem_req), 32'd1);
        chk("t6_addr0", 32'(bus.imem_addr), 32'd0);

        // 6b: reset during MREAD
        fetch(16'h0003); tick();
        fetch(16'hFC10); tick();
        chk("t6_rd", 32'(bus.dmem_rd), 32'd1);
        chk("t6_raddr", 32'(bus.dmem_addr), 32'd3);
        reset = 1'b1;
        tick();
        chk("t6_rd_abort", 32'(bus.dmem_rd), 32'd0);
        chk("t6_pc_b", 32'(pc), 32'd0);
        chk("t6_a_b", 32'(a_reg), 32'd0);
        reset = 1'b0;
        tick();

        // 6c: PC wrap at 0x7FFF
        fetch(16'h7FFF); tick();
        fetch(16'hEA87); tick(); tick();
        chk("t6_jmp_top", 32'(pc), 32'h7FFF);
        chk("t6_addr_top", 32'(bus.imem_addr), 32'h7FFF);
        fetch(16'h0001); tick();
        chk("t6_wrap", 32'(pc), 32'd0);
        chk("t6_wrap_a", 32'(a_reg), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
